// File: rtl/serial_subtractor_func.sv
// Bit-serial subtractor: a - b - borrow_in, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf_out.
module serial_subtractor_func #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             bor;
    logic             bor_nxt;
    logic             d;
    logic             last;
    logic             accept;

    // Full-subtractor cell on the current LSBs
    assign d       = a_sr[0] ^ b_sr[0] ^ bor;
    assign bor_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bor);
    assign res_nxt = {d, res_sr[WIDTH-1:1]};
    assign last    = (cnt == CW'(WIDTH - 1));
    assign accept  = start_in && (state == IDLE || state == DONE);

    assign busy_out = (state == RUN);
    assign done_out = (state == DONE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_in) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start_in ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            bor        <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            a_sr   <= a_in;
            b_sr   <= b_in;
            res_sr <= '0;
            cnt    <= '0;
            bor    <= borrow_in;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            cnt    <= cnt + 1'b1;
            bor    <= bor_nxt;
            if (last) begin
                diff_out   <= res_nxt;
                borrow_out <= bor_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Borrow into the MSB differs from borrow out of it on signed overflow
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ovf_out <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_out <= bor ^ bor_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_func.sv
// Directed bench for serial_subtractor_func at WIDTH = 8.
// Define SERIAL_SUB_OVF_EN to also check ovf_out.
module tb_serial_subtractor_func;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_done;

    always #5 clk = ~clk;

    serial_subtractor_func #(.WIDTH(W)) dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .start_in   (start),
        .a_in       (a),
        .b_in       (b),
        .borrow_in  (bin),
        .busy_out   (busy),
        .done_out   (done),
        .diff_out   (diff),
        .borrow_out (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf_out    (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tbi,
                          input logic [W-1:0] ed, input logic eb,
                          input logic eo);
        @(negedge clk);
        a     = ta;
        b     = tb;
        bin   = tbi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check({tag, "_run"}, 32'({busy, done}), 32'h2);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'({busy, done}), 32'h1);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo) n_chk += 0;
`endif
        @(negedge clk);
        check({tag, "_idle"}, 32'({busy, done}), 32'h0);
        check({tag, "_hold"}, 32'(diff), 32'(ed));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #12;
        check("rst_ctl", 32'({busy, done}), 32'h0);
        check("rst_diff", 32'(diff), 32'h0);
        check("rst_bout", 32'(bout), 32'h0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(ovf), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        run_op("basic", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op("under1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("under2", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("ovf1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("ovf2", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // Start pulse during RUN must be ignored
        @(negedge clk);
        a     = 8'h20;
        b     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 8'h00;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                check("ign_pos", 32'(i), 32'd5);
                check("ign_diff", 32'(diff), 32'h1F);
                check("ign_bout", 32'(bout), 32'h0);
            end
        end
        check("ign_ndone", 32'(n_done), 32'd1);

        // Back-to-back with start held high
        @(negedge clk);
        a     = 8'h05;
        b     = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h03;
        b = 8'h05;
        for (int i = 0; i <= 2 * W + 1; i++) begin
            @(negedge clk);
            if (i == W || i == 2 * W + 1)
                check("b2b_ctl", 32'({busy, done}), 32'h1);
            else
                check("b2b_ctl", 32'({busy, done}), 32'h2);
            if (i == W) begin
                check("b2b_diff1", 32'(diff), 32'h02);
                check("b2b_bout1", 32'(bout), 32'h0);
            end
            if (i == 2 * W + 1) begin
                check("b2b_diff2", 32'(diff), 32'hFE);
                check("b2b_bout2", 32'(bout), 32'h1);
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", 32'({busy, done}), 32'h0);

        // Asynchronous reset in the middle of RUN
        run_op("pre_rst", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        @(negedge clk);
        a     = 8'h44;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_ctl", 32'({busy, done}), 32'h0);
        check("mrst_diff", 32'(diff), 32'h0);
        check("mrst_bout", 32'(bout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("mrst_quiet", 32'(n_done), 32'd0);
        run_op("post_rst", 8'h44, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
